des_region_dispatcher: RTL and testbench
========================================

# des_region_dispatcher

Host-side sequencer for one `des_block` worker: it drives the worker's `start`/`region_select`/`counter`/`valid` handshake from the initiator side. On a `go` command it walks a contiguous range of 16-bit regions. For each region it launches the worker, waits for `valid`, captures the 10-bit count and streams it out over a valid/ready result port. It keeps a running total and pulses `done` when the range is exhausted.

## Interface
- `CNT_W`, 10: width of worker count (`blk_counter`).
- `TOT_W`, 26: width of `total_count`; holds 1023 × 65536 without overflow.
- `clk` input 1: clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `go` input 1: single-cycle command, sampled only in IDLE.
- `first_region` input 16: first region index, captured on `go`.
- `num_regions` input 17: region count (0..65536), captured on `go`.
- `abort` input 1: stop the run after the current region releases.
- `blk_start` output 1: to worker `start`, registered.
- `blk_region_select` output 16: to worker `region_select`, registered.
- `blk_counter` input CNT_W: from worker `counter`.
- `blk_valid` input 1: from worker `valid`.
- `res_valid` output 1: result beat available.
- `res_ready` input 1: consumer accepts the beat.
- `res_region` output 16: region index of the beat.
- `res_count` output CNT_W: worker count of the beat.
- `total_count` output TOT_W: sum of all counts in the current run.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on normal completion.
- `aborted` output 1: one-cycle pulse on abort completion.

## Operation
- Reset values: all outputs 0, state IDLE. Reset is asynchronous; asserting it mid-run drops `blk_start` immediately, and the worker returns to init on its own.
- States:
  - IDLE, on `go`:
    - `num_regions` == 0: pulse `done` next cycle with `total_count` = 0, and stay IDLE.
    - otherwise: latch `region` = `first_region` and `remaining` = `num_regions`, clear `total_count`, go to LAUNCH.
  - LAUNCH: set `blk_region_select` = `region`, `blk_start` = 1, go to WAIT.
  - WAIT: on `blk_valid` = 1:
    - capture `res_count` = `blk_counter` and `res_region` = `region`;
    - set `res_valid` = 1 and `total_count` += `blk_counter`;
    - go to REPORT.
  - REPORT: hold `blk_start` = 1, because the worker keeps `counter` valid only while `start` is high. On `res_valid` && `res_ready`:
    - clear `res_valid` and `blk_start`, decrement `remaining`, go to RELEASE.
  - RELEASE: wait for `blk_valid` = 0.
    - `remaining` == 0: go to IDLE and pulse `done`.
    - abort pending: go to IDLE and pulse `aborted`.
    - otherwise: `region` += 1 (mod 2^16, so 0xFFFF wraps to 0x0000), go to LAUNCH.
- `abort`:
  - sets a sticky pending flag in any non-IDLE state.
  - in LAUNCH or WAIT: drop `blk_start` the next cycle, emit no result beat, go to RELEASE.
  - in REPORT: the beat still completes normally.
  - `abort` in IDLE is ignored; `go` outside IDLE is ignored.
  - if `remaining` reaches 0 and an abort is pending in the same RELEASE exit, `done` wins.
- `blk_region_select` is stable for the whole time `blk_start` is high.
- `blk_valid` is ignored outside WAIT. RELEASE guarantees a stale `valid` from the previous region is never sampled as a new result.
- `total_count` is unsigned, zero-extended add; it cannot overflow for legal ranges. It holds its value after `done` until the next accepted `go`.
- `res_valid`, `res_region` and `res_count` stay stable until the beat is accepted (AXI-stream rule). `res_ready` may be high before `res_valid`.

## Timing
- `go` at cycle 0 → LAUNCH at cycle 1 → `blk_start` = 1 at cycle 2.
- `blk_valid` sampled high at cycle N → `res_valid` = 1 and updated `total_count` at cycle N+1.
- With `res_ready` held high: handshake at cycle N+1 → `blk_start` = 0 at cycle N+2.
- `blk_valid` sampled low at cycle M → `blk_start` = 1 for the next region at M+2 (one LAUNCH cycle), or `done`/`aborted` high at M+1.
- Per-region dispatcher overhead with `res_ready` = 1 is 4 cycles plus the worker latency.
- Back-to-back `go` is accepted in the same cycle that IDLE is re-entered after `done`.

## Test plan
- Single region: behavioral worker returns 0x155 after 20 cycles; `go`, `first_region` = 0x0007, `num_regions` = 1 → one beat (0x0007, 0x155), `total_count` = 0x155, `done` pulses once, `blk_start` low at end.
- Wrap: `first_region` = 0xFFFE, `num_regions` = 3, counts 1, 2, 3 → beats on regions 0xFFFE, 0xFFFF, 0x0000; `total_count` = 6.
- Backpressure: `res_ready` low for 10 cycles after `res_valid` → `blk_start` stays 1 and beat fields stay stable; accept → next region launches only after `blk_valid` falls.
- Zero range: `num_regions` = 0 → `done` one cycle after `go`, `blk_start` never rises, `total_count` = 0.
- Abort in WAIT: abort during the 2nd of 5 regions → no beat for region 2, `blk_start` drops, `aborted` pulses after `blk_valid` is low, `total_count` = region 1 count only.
- Reset mid-REPORT: assert `rst_n` = 0 asynchronously → all outputs 0 in the same cycle, state IDLE; a new `go` then runs correctly.

Source files
------------

// File: rtl/des_region_dispatcher_if.sv
// Worker handshake and result stream bundle for des_region_dispatcher.
// The master side is the dispatcher; the slave side is the worker plus result consumer.
interface des_region_dispatcher_if #(
  parameter int CNT_W = 10
);
  logic             blk_start;
  logic [15:0]      blk_region_select;
  logic [CNT_W-1:0] blk_counter;
  logic             blk_valid;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_region;
  logic [CNT_W-1:0] res_count;

  modport master (
    output blk_start, blk_region_select, res_valid, res_region, res_count,
    input  blk_counter, blk_valid, res_ready
  );

  modport slave (
    input  blk_start, blk_region_select, res_valid, res_region, res_count,
    output blk_counter, blk_valid, res_ready
  );
endinterface

// File: rtl/des_region_dispatcher.sv
// Sequences one des_block worker over a contiguous range of 16-bit regions,
// streaming each region's count out and keeping a running total.
module des_region_dispatcher #(
  parameter int CNT_W = 10,
  parameter int TOT_W = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [15:0]            first_region,
  input  logic [16:0]            num_regions,
  input  logic                   abort,
  des_region_dispatcher_if.master bus,
  output logic [TOT_W-1:0]       total_count,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_REPORT,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      region_q, region_d;
  logic [16:0]      remaining_q, remaining_d;
  logic             abort_pend_q, abort_pend_d;
  logic             blk_start_q, blk_start_d;
  logic [15:0]      blk_sel_q, blk_sel_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_region_q, res_region_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      region_q     <= '0;
      remaining_q  <= '0;
      abort_pend_q <= 1'b0;
      blk_start_q  <= 1'b0;
      blk_sel_q    <= '0;
      res_valid_q  <= 1'b0;
      res_region_q <= '0;
      res_count_q  <= '0;
      total_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      remaining_q  <= remaining_d;
      abort_pend_q <= abort_pend_d;
      blk_start_q  <= blk_start_d;
      blk_sel_q    <= blk_sel_d;
      res_valid_q  <= res_valid_d;
      res_region_q <= res_region_d;
      res_count_q  <= res_count_d;
      total_q      <= total_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    remaining_d  = remaining_q;
    abort_pend_d = abort_pend_q;
    blk_start_d  = blk_start_q;
    blk_sel_d    = blk_sel_q;
    res_valid_d  = res_valid_q;
    res_region_d = res_region_q;
    res_count_d  = res_count_q;
    total_d      = total_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    if (state_q != S_IDLE && abort) begin
      abort_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          total_d = '0;
          if (num_regions == '0) begin
            done_d = 1'b1;
          end else begin
            region_d     = first_region;
            remaining_d  = num_regions;
            abort_pend_d = 1'b0;
            state_d      = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        if (abort) begin
          blk_start_d = 1'b0;
          state_d     = S_RELEASE;
        end else begin
          blk_sel_d   = region_q;
          blk_start_d = 1'b1;
          state_d     = S_WAIT;
        end
      end

      // An abort here wins over a simultaneous valid, so no beat leaks out.
      S_WAIT: begin
        if (abort) begin
          blk_start_d = 1'b0;
          state_d     = S_RELEASE;
        end else if (bus.blk_valid) begin
          res_count_d  = bus.blk_counter;
          res_region_d = region_q;
          res_valid_d  = 1'b1;
          total_d      = total_q + TOT_W'(bus.blk_counter);
          state_d      = S_REPORT;
        end
      end

      S_REPORT: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          blk_start_d = 1'b0;
          remaining_d = remaining_q - 17'd1;
          state_d     = S_RELEASE;
        end
      end

      // Completion takes priority over a pending abort on the last region.
      S_RELEASE: begin
        if (!bus.blk_valid) begin
          if (remaining_q == '0) begin
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
          end else if (abort_pend_q || abort) begin
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            region_d = region_q + 16'd1;
            state_d  = S_LAUNCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.blk_start         = blk_start_q;
  assign bus.blk_region_select = blk_sel_q;
  assign bus.res_valid         = res_valid_q;
  assign bus.res_region        = res_region_q;
  assign bus.res_count         = res_count_q;
  assign total_count           = total_q;
  assign busy                  = (state_q != S_IDLE);
  assign done                  = done_q;
  assign aborted               = aborted_q;

endmodule

// File: tb/tb_des_region_dispatcher.sv
// Self-checking bench: behavioural worker, scoreboard of expected beats and
// launches built from the region range, plus directed literal checks.
module tb_des_region_dispatcher;
  localparam int CNT_W = 10;
  localparam int TOT_W = 26;

  typedef struct {
    logic [15:0]      region;
    logic [CNT_W-1:0] count;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             go;
  logic             abort;
  logic [15:0]      first_region;
  logic [16:0]      num_regions;
  logic [TOT_W-1:0] total_count;
  logic             busy;
  logic             done;
  logic             aborted;

  des_region_dispatcher_if #(.CNT_W(CNT_W)) bus ();

  des_region_dispatcher #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .first_region (first_region),
    .num_regions  (num_regions),
    .abort        (abort),
    .bus          (bus.master),
    .total_count  (total_count),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  int n_checks = 0;
  int n_errors = 0;
  beat_t exp_q[$];
  logic [15:0] launch_q[$];
  logic [CNT_W-1:0] cnt_map [logic [15:0]];
  int wk_lat = 4;
  int wk_rel = 2;
  int done_seen = 0;
  int aborted_seen = 0;
  int start_rises = 0;
  logic [TOT_W-1:0] sum_model = '0;
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats and launches follow directly from the range with 16-bit wrap.
  task automatic push_run(input logic [15:0] first, input int num);
    for (int i = 0; i < num; i++) begin
      beat_t b;
      b.region = first + 16'(i);
      b.count  = cnt_map[b.region];
      exp_q.push_back(b);
      launch_q.push_back(b.region);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] first, input logic [16:0] num);
    first_region = first;
    num_regions  = num;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_end(input int budget, output logic got_done, output logic got_abort);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done || aborted) break;
    end
    got_done  = done;
    got_abort = aborted;
    checkOutput("run_end_seen", 32'(done | aborted), 32'd1);
  endtask

  task automatic wait_res_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.res_valid) break;
      tick();
    end
    checkOutput("res_valid_seen", 32'(bus.res_valid), 32'd1);
  endtask

  // Behavioural worker: counter appears wk_lat cycles after start, valid
  // lingers wk_rel cycles after start falls.
  initial begin : worker
    bit active = 1'b0;
    int timer  = 0;
    int drop   = 0;
    bus.blk_valid   = 1'b0;
    bus.blk_counter = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
        bus.blk_valid   = 1'b0;
        bus.blk_counter = '0;
      end else if (bus.blk_start) begin
        if (!active) begin
          active = 1'b1;
          timer  = 0;
        end else if (!bus.blk_valid) begin
          timer++;
          if (timer >= wk_lat) begin
            bus.blk_valid   = 1'b1;
            bus.blk_counter = cnt_map[bus.blk_region_select];
          end
        end
      end else begin
        if (active) begin
          active = 1'b0;
          drop   = wk_rel;
        end
        if (bus.blk_valid) begin
          if (drop <= 1) begin
            bus.blk_valid   = 1'b0;
            bus.blk_counter = '0;
          end else begin
            drop--;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 32'd1, 32'd0);
        end else begin
          checkOutput("beat_region", 32'(bus.res_region), 32'(exp_q[0].region));
          checkOutput("beat_count", 32'(bus.res_count), 32'(exp_q[0].count));
          if (bus.res_ready) begin
            sum_model = sum_model + TOT_W'(exp_q[0].count);
            checkOutput("total_at_accept", 32'(total_count), 32'(sum_model));
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.blk_start) begin
        if (launch_q.size() == 0) checkOutput("unexpected_launch", 32'd1, 32'd0);
        else checkOutput("region_select", 32'(bus.blk_region_select), 32'(launch_q[0]));
        if (!prev_start) begin
          start_rises++;
          checkOutput("launch_after_release", 32'(prev_valid), 32'd0);
        end
      end else if (prev_start && launch_q.size() > 0) begin
        void'(launch_q.pop_front());
      end
      if (!busy) begin
        checkOutput("idle_start_low", 32'(bus.blk_start), 32'd0);
        checkOutput("idle_res_valid_low", 32'(bus.res_valid), 32'd0);
      end
      if (done) begin
        done_seen++;
        checkOutput("total_at_done", 32'(total_count), 32'(sum_model));
      end
      if (aborted) begin
        aborted_seen++;
        checkOutput("total_at_abort", 32'(total_count), 32'(sum_model));
      end
      checkOutput("done_aborted_exclusive", 32'(done & aborted), 32'd0);
      if (go && !busy) sum_model = '0;
      prev_start = bus.blk_start;
      prev_valid = bus.blk_valid;
    end
  end

  initial begin
    logic gd, ga;
    int d0, s0;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0;
    first_region = '0; num_regions = '0;
    bus.res_ready = 1'b1;
    #3;
    checkOutput("reset_blk_start", 32'(bus.blk_start), 32'd0);
    checkOutput("reset_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("reset_total", 32'(total_count), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done | aborted), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single region");
    wk_lat = 20; wk_rel = 2;
    cnt_map[16'h0007] = 10'h155;
    push_run(16'h0007, 1);
    d0 = done_seen;
    applyStimulus(16'h0007, 17'd1);
    checkOutput("cycle1_start_low", 32'(bus.blk_start), 32'd0);
    checkOutput("cycle1_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("cycle2_start_high", 32'(bus.blk_start), 32'd1);
    checkOutput("cycle2_region", 32'(bus.blk_region_select), 32'h0007);
    wait_end(100, gd, ga);
    checkOutput("single_done", 32'(gd), 32'd1);
    checkOutput("single_total", 32'(total_count), 32'h155);
    tick();
    checkOutput("single_done_pulse", 32'(done), 32'd0);
    checkOutput("single_done_once", 32'(done_seen - d0), 32'd1);
    checkOutput("single_start_low", 32'(bus.blk_start), 32'd0);
    checkOutput("single_beats_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] wrap");
    wk_lat = 3; wk_rel = 1;
    cnt_map[16'hFFFE] = 10'd1; cnt_map[16'hFFFF] = 10'd2; cnt_map[16'h0000] = 10'd3;
    push_run(16'hFFFE, 3);
    applyStimulus(16'hFFFE, 17'd3);
    wait_end(200, gd, ga);
    checkOutput("wrap_done", 32'(gd), 32'd1);
    checkOutput("wrap_total", 32'(total_count), 32'd6);
    checkOutput("wrap_beats_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] backpressure");
    wk_lat = 5; wk_rel = 4;
    cnt_map[16'h0100] = 10'h3FF; cnt_map[16'h0101] = 10'h200;
    bus.res_ready = 1'b0;
    push_run(16'h0100, 2);
    applyStimulus(16'h0100, 17'd2);
    wait_res_valid(100);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_start_held", 32'(bus.blk_start), 32'd1);
      checkOutput("bp_valid_held", 32'(bus.res_valid), 32'd1);
    end
    bus.res_ready = 1'b1;
    wait_end(200, gd, ga);
    checkOutput("bp_done", 32'(gd), 32'd1);
    checkOutput("bp_total", 32'(total_count), 32'h5FF);

    $display("[TB] zero range");
    s0 = start_rises;
    applyStimulus(16'h1234, 17'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_total", 32'(total_count), 32'd0);
    tick();
    checkOutput("zero_done_pulse", 32'(done), 32'd0);
    checkOutput("zero_no_launch", 32'(start_rises - s0), 32'd0);

    $display("[TB] abort in wait");
    wk_lat = 20; wk_rel = 2;
    for (int i = 0; i < 5; i++) cnt_map[16'h0010 + 16'(i)] = 10'h011 * 10'(i + 1);
    exp_q.push_back('{region: 16'h0010, count: 10'h011});
    launch_q.push_back(16'h0010);
    launch_q.push_back(16'h0011);
    applyStimulus(16'h0010, 17'd5);
    for (int i = 0; i < 200; i++) begin
      if (bus.blk_start && bus.blk_region_select == 16'h0011) break;
      tick();
    end
    checkOutput("abort_second_launch", 32'(bus.blk_region_select), 32'h0011);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_drops_start", 32'(bus.blk_start), 32'd0);
    wait_end(50, gd, ga);
    checkOutput("abort_pulse", 32'(ga), 32'd1);
    checkOutput("abort_no_done", 32'(gd), 32'd0);
    checkOutput("abort_total", 32'(total_count), 32'h011);
    tick();
    checkOutput("abort_beats_left", 32'(exp_q.size()), 32'd0);
    checkOutput("abort_launches_left", 32'(launch_q.size()), 32'd0);

    $display("[TB] back-to-back go");
    wk_lat = 2; wk_rel = 0;
    cnt_map[16'h0020] = 10'd5; cnt_map[16'h0030] = 10'd7;
    push_run(16'h0020, 1);
    applyStimulus(16'h0020, 17'd1);
    wait_end(100, gd, ga);
    checkOutput("b2b_first_total", 32'(total_count), 32'd5);
    push_run(16'h0030, 1);
    applyStimulus(16'h0030, 17'd1);
    checkOutput("b2b_accepted", 32'(busy), 32'd1);
    wait_end(100, gd, ga);
    checkOutput("b2b_done", 32'(gd), 32'd1);
    checkOutput("b2b_total", 32'(total_count), 32'd7);

    $display("[TB] reset mid-report");
    wk_lat = 3; wk_rel = 2;
    cnt_map[16'h0040] = 10'h0AA; cnt_map[16'h0041] = 10'h0CC;
    bus.res_ready = 1'b0;
    push_run(16'h0040, 2);
    applyStimulus(16'h0040, 17'd2);
    wait_res_valid(100);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_blk_start", 32'(bus.blk_start), 32'd0);
    checkOutput("rst_region_sel", 32'(bus.blk_region_select), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_fields", 32'({bus.res_region, bus.res_count}), 32'd0);
    checkOutput("rst_total", 32'(total_count), 32'd0);
    checkOutput("rst_flags", 32'({busy, done, aborted}), 32'd0);
    exp_q.delete();
    launch_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    cnt_map[16'h0050] = 10'h0BB;
    push_run(16'h0050, 1);
    applyStimulus(16'h0050, 17'd1);
    wait_end(100, gd, ga);
    checkOutput("post_rst_done", 32'(gd), 32'd1);
    checkOutput("post_rst_total", 32'(total_count), 32'h0BB);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
